// File: rtl/reg_file_read_port_if.sv
// Bus bundle for the register bank: one write port plus a handshaked read port.
// The producer side (operand fetch / CPU) uses the master modport; the bank
// uses the slave modport.
interface reg_file_read_port_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              inWrEn;
  logic [ADDR_W-1:0] inWrAddr;
  logic [DATA_W-1:0] inWrData;
  logic              inRdReq;
  logic [ADDR_W-1:0] inRdAddr;
  logic              outRdGnt;
  logic              outRdValid;
  logic [DATA_W-1:0] outRdData;
  logic              inRdTake;

  modport master (
    output inWrEn, inWrAddr, inWrData,
    output inRdReq, inRdAddr, inRdTake,
    input  outRdGnt, outRdValid, outRdData
  );

  modport slave (
    input  inWrEn, inWrAddr, inWrData,
    input  inRdReq, inRdAddr, inRdTake,
    output outRdGnt, outRdValid, outRdData
  );
endinterface

// File: rtl/reg_file_read_port.sv
// Register bank with a single write port and a one-deep handshaked read port.
// A read accepted on an edge presents its word from that edge on, and the word
// is held as a snapshot until the consumer takes it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no untaken word on outRdData; grant is always high
// VALID | outRdData holds an untaken word; grant only when it is taken
module reg_file_read_port #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input logic                 inClk,
  input logic                 inClrN,
  reg_file_read_port_if.slave bus
);

  localparam int  Depth   = 2 ** ADDR_W;
  localparam bit  ZeroReg = (ZERO_REG != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } stateT;

  stateT             state;
  stateT             stateNxt;
  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] rdData;
  logic [DATA_W-1:0] rdWord;
  logic              rdGnt;
  logic              rdAccept;
  logic              loadData;
  logic              rdIsZeroReg;
  logic              wrIsZeroReg;
  logic              wrHitsRd;

  assign rdIsZeroReg = ZeroReg && (bus.inRdAddr == '0);
  assign wrIsZeroReg = ZeroReg && (bus.inWrAddr == '0);
  assign wrHitsRd    = bus.inWrEn && (bus.inWrAddr == bus.inRdAddr);

  // Word the read port captures on acceptance: hard zero, bypassed write data, or storage.
  always_comb begin
    rdWord = mem[bus.inRdAddr];
    if (rdIsZeroReg) begin
      rdWord = '0;
    end else if (wrHitsRd) begin
      rdWord = bus.inWrData;
    end
  end

  // Next-state and handshake decode; grant depends on the current take, not on the request.
  always_comb begin
    stateNxt = state;
    rdGnt    = 1'b1;
    rdAccept = 1'b0;
    loadData = 1'b0;
    case (state)
      IDLE: begin
        rdGnt    = 1'b1;
        rdAccept = bus.inRdReq;
        if (rdAccept) begin
          loadData = 1'b1;
          stateNxt = VALID;
        end
      end
      VALID: begin
        rdGnt    = bus.inRdTake;
        rdAccept = bus.inRdReq && bus.inRdTake;
        if (rdAccept) begin
          loadData = 1'b1;
          stateNxt = VALID;
        end else if (bus.inRdTake) begin
          stateNxt = IDLE;
        end
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  // State register; reset clears any pending word immediately.
  always_ff @(posedge inClk or negedge inClrN) begin
    if (!inClrN) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // Read data register; only an accepted read changes it, so a take alone leaves the last word visible.
  always_ff @(posedge inClk or negedge inClrN) begin
    if (!inClrN) begin
      rdData <= '0;
    end else if (loadData) begin
      rdData <= rdWord;
    end
  end

  // Storage array; writes never stall and word 0 stays zero when it is hardwired.
  always_ff @(posedge inClk or negedge inClrN) begin
    if (!inClrN) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.inWrEn && !wrIsZeroReg) begin
      mem[bus.inWrAddr] <= bus.inWrData;
    end
  end

  assign bus.outRdGnt   = rdGnt;
  assign bus.outRdValid = (state == VALID);
  assign bus.outRdData  = rdData;

endmodule
